adc_align_ctrl: RTL and testbench
=================================

Name: adc_align_ctrl

Overview:
- Bit/word-alignment training controller for the two-lane ADC LVDS receive path. Runs in the CLKDIV (parallel) domain.
- Drives the shared deserializer reset, CE and bitslip controls.
- Compares the reassembled 16-bit sample word against the ADC's programmed training pattern.
- Issues bitslip pulses until the pattern is received stably, then reports lock or failure.

Parameters:
- PATTERN, 16'hA1B2, expected training word as seen on the reassembled 16-bit sample bus.
- RST_CYCLES, 8, CLKDIV cycles serdes_rst is held high.
- SETTLE_CYCLES, 16, cycles after deserializer reset release before the first compare.
- MATCH_CNT, 16, consecutive matching words required to declare lock (>=1).
- SLIP_WAIT, 4, cycles after a bitslip pulse before comparing resumes (>=2).
- MAX_SLIPS, 8, number of word positions to try (deserialization ratio).

Ports:
- CLKDIV  in  1  parallel-domain clock.
- RST_N  in  1  async-assert, active-low reset.
- start  in  1  pulse; begins or restarts training.
- d_in  in  16  reassembled deserializer sample word, valid every CLKDIV cycle.
- serdes_rst  out  1  deserializer reset, to the receive path RST.
- serdes_ce  out  1  deserializer clock enable.
- bitslip  out  1  single-cycle bitslip pulse, shared by both lanes.
- busy  out  1  training in progress.
- aligned  out  1  lock achieved.
- fail  out  1  all positions tried without lock.
- slip_cnt  out  $clog2(MAX_SLIPS)  bitslips issued in the current attempt.

Behaviour:
- Clock, reset and outputs:
  - One clock, CLKDIV. Reset RST_N is asynchronous, active-low.
  - All outputs are registered.
- Reset values:
  - State IDLE.
  - serdes_rst=1 (receive path held in reset until trained).
  - serdes_ce=0, bitslip=0, busy=0, aligned=0, fail=0, slip_cnt=0.
  - Internal counters 0.
- IDLE:
  - Outputs as reset.
  - start=1 -> SRST.
- SRST:
  - serdes_rst=1, serdes_ce=0, busy=1, aligned=0, fail=0, slip_cnt=0.
  - Held for RST_CYCLES cycles, then -> SETTLE.
- SETTLE:
  - serdes_rst=0, serdes_ce=1.
  - Held for SETTLE_CYCLES cycles, then -> COMPARE with match counter=0.
- COMPARE (one d_in sample per cycle):
  - Match: increment match counter. On the MATCH_CNT-th consecutive match -> LOCKED.
  - Mismatch with slip_cnt < MAX_SLIPS-1: clear match counter -> SLIP.
  - Mismatch with slip_cnt == MAX_SLIPS-1: -> FAIL.
- SLIP:
  - Exactly one cycle.
  - bitslip=1 and slip_cnt increments, both on that cycle.
  - -> SWAIT.
- SWAIT:
  - bitslip=0, d_in ignored, for SLIP_WAIT cycles.
  - -> COMPARE with match counter=0.
- LOCKED:
  - aligned=1, busy=0, serdes_ce=1, serdes_rst=0.
  - slip_cnt holds the final offset.
- FAIL:
  - fail=1, busy=0, serdes_ce=1, serdes_rst=0.
  - slip_cnt = MAX_SLIPS-1.
- start handling:
  - Ignored while busy=1.
  - In LOCKED or FAIL, start=1 -> SRST; aligned and fail clear on entry to SRST.
- Bitslip spacing:
  - Consecutive bitslip pulses are separated by >= SLIP_WAIT+1 cycles.
  - bitslip is never high for two consecutive cycles.
- Lock latency:
  - With no slips, aligned rises exactly 1+RST_CYCLES+SETTLE_CYCLES+MATCH_CNT cycles after the cycle start is sampled (defaults: 41).
  - Each slip adds 1 + SLIP_WAIT cycles plus the compare cycles consumed before the mismatch.
- Reset mid-operation:
  - RST_N low in any state forces reset values immediately (async), including bitslip=0.
  - Training does not resume until a new start.
- Counters:
  - Sized to hold the maximum count without wrap.
  - slip_cnt never exceeds MAX_SLIPS-1.

Test Plan:
- Aligned from start: d_in constantly 16'hA1B2; start pulse at cycle 0 -> serdes_rst high cycles 1-8, aligned=1 at cycle 41, slip_cnt=0, no bitslip pulses.
- Offset 3: model rotates the pattern position until 3 bitslips are received -> exactly 3 single-cycle bitslip pulses each >=5 cycles apart, aligned=1, slip_cnt=3.
- Never matches: d_in=16'h0000 -> 7 bitslip pulses, then fail=1, aligned=0, busy=0, slip_cnt=7.
- Glitch:
  - Stimulus: correct pattern, except one mismatching word at the 10th compare sample.
  - Response: one bitslip pulse, match count restarts.
  - If the model holds alignment across that slip, position 1 is then tried.
  - Final state follows the model; no lock is declared before 16 consecutive matches.
- start while busy is ignored (no restart, state unchanged). start in LOCKED -> aligned drops, serdes_rst reasserts for 8 cycles, training repeats.
- RST_N low during SWAIT -> all outputs at reset values immediately, including serdes_rst=1. After release, state is IDLE until start.

Source files
------------

// File: rtl/adc_align_ctrl.sv
// adc_align_ctrl: bit/word alignment trainer for the two-lane ADC LVDS rx path.
// Drives deserializer rst/ce/bitslip until d_in matches PATTERN stably.
// Ports:
//   CLKDIV, RST_N  parallel clock, async active-low reset
//   start          pulse, begins or restarts training (ignored while busy)
//   d_in           reassembled 16-bit sample word, one per cycle
//   serdes_rst     deserializer reset
//   serdes_ce      deserializer clock enable
//   bitslip        single-cycle slip pulse, shared by both lanes
//   busy           training in progress
//   aligned, fail  lock achieved / all positions tried
//   slip_cnt       bitslips issued in the current attempt
module adc_align_ctrl #(
  parameter logic [15:0] PATTERN       = 16'hA1B2,
  parameter int          RST_CYCLES    = 8,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          MATCH_CNT     = 16,
  parameter int          SLIP_WAIT     = 4,
  parameter int          MAX_SLIPS     = 8
) (
  input  logic                         CLKDIV,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic [15:0]                  d_in,
  output logic                         serdes_rst,
  output logic                         serdes_ce,
  output logic                         bitslip,
  output logic                         busy,
  output logic                         aligned,
  output logic                         fail,
  output logic [$clog2(MAX_SLIPS)-1:0] slip_cnt
);

  localparam int CMAX0 = (RST_CYCLES > SETTLE_CYCLES) ?
                         RST_CYCLES : SETTLE_CYCLES;
  localparam int CMAX  = (CMAX0 > SLIP_WAIT) ? CMAX0 : SLIP_WAIT;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int MW    = $clog2(MATCH_CNT + 1);
  localparam int SW    = $clog2(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRST,
    S_SETTLE,
    S_COMPARE,
    S_SLIP,
    S_SWAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [MW-1:0] match, match_n;
  logic [SW-1:0] slip_q, slip_n;

  logic rst_c, ce_c, bs_c, busy_c, al_c, fl_c;

  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      match  <= '0;
      slip_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      match  <= match_n;
      slip_q <= slip_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    match_n = match;
    slip_n  = slip_q;
    unique case (state)
      S_IDLE, S_LOCKED, S_FAIL: begin
        if (start) begin
          state_n = S_SRST;
          cnt_n   = '0;
          match_n = '0;
          slip_n  = '0;
        end
      end
      S_SRST: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_n = S_COMPARE;
          cnt_n   = '0;
          match_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_COMPARE: begin
        if (d_in == PATTERN) begin
          match_n = match + 1'b1;
          if (match == MW'(MATCH_CNT - 1))
            state_n = S_LOCKED;
        end else if (slip_q == SW'(MAX_SLIPS - 1)) begin
          state_n = S_FAIL;
        end else begin
          state_n = S_SLIP;
          match_n = '0;
        end
      end
      S_SLIP: begin
        state_n = S_SWAIT;
        slip_n  = slip_q + 1'b1;
        cnt_n   = '0;
      end
      S_SWAIT: begin
        if (cnt == CW'(SLIP_WAIT - 1)) begin
          state_n = S_COMPARE;
          cnt_n   = '0;
          match_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rst_c  = 1'b0;
    ce_c   = 1'b1;
    bs_c   = 1'b0;
    busy_c = 1'b1;
    al_c   = 1'b0;
    fl_c   = 1'b0;
    unique case (state)
      S_IDLE: begin
        rst_c  = 1'b1;
        ce_c   = 1'b0;
        busy_c = 1'b0;
      end
      S_SRST: begin
        rst_c = 1'b1;
        ce_c  = 1'b0;
      end
      S_SLIP:   bs_c = 1'b1;
      S_LOCKED: begin
        busy_c = 1'b0;
        al_c   = 1'b1;
      end
      S_FAIL: begin
        busy_c = 1'b0;
        fl_c   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      serdes_rst <= 1'b1;
      serdes_ce  <= 1'b0;
      bitslip    <= 1'b0;
      busy       <= 1'b0;
      aligned    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      serdes_rst <= rst_c;
      serdes_ce  <= ce_c;
      bitslip    <= bs_c;
      busy       <= busy_c;
      aligned    <= al_c;
      fail       <= fl_c;
    end
  end

  // slip_q updates on the same edge that raises bitslip
  assign slip_cnt = slip_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// tb_adc_align_ctrl: scoreboard bench for adc_align_ctrl.
// ADC model rotates word position on each bitslip.
module tb_adc_align_ctrl;

  localparam logic [15:0] PAT = 16'hA1B2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] d_in;
  logic        serdes_rst, serdes_ce, bitslip;
  logic        busy, aligned, fail;
  logic [2:0]  slip_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s0 = 0;
  int pos = 0;
  int target = 0;
  int nslips = 0;
  int last_bs = -1;
  int rst_low = -1;
  bit zero_mode = 1'b0;
  bit prev_bs = 1'b0;
  bit seen_high = 1'b0;

  typedef struct {
    bit al;
    bit fl;
    int sc;
    int ns;
    int lat;
  } exp_t;

  exp_t sb[$];

  adc_align_ctrl dut (
    .CLKDIV    (clk),
    .RST_N     (rst_n),
    .start     (start),
    .d_in      (d_in),
    .serdes_rst(serdes_rst),
    .serdes_ce (serdes_ce),
    .bitslip   (bitslip),
    .busy      (busy),
    .aligned   (aligned),
    .fail      (fail),
    .slip_cnt  (slip_cnt)
  );

  always #5 clk = ~clk;

  assign d_in = zero_mode ? 16'h0000 :
                (((pos % 8) == target) ? PAT : ~PAT);

  always @(posedge clk) begin
    cyc++;
    if (bitslip) begin
      checks++;
      if (prev_bs) begin
        failures++;
        $display("FAIL bitslip_width cyc=%0d got two-cycle pulse want one", cyc);
      end
      if (last_bs >= 0) begin
        checks++;
        if (cyc - last_bs < 5) begin
          failures++;
          $display("FAIL bitslip_gap got=%0d want>=5", cyc - last_bs);
        end
      end
      last_bs = cyc;
      nslips++;
      pos++;
    end
    prev_bs = bitslip;
  end

  always @(negedge clk) begin
    if (serdes_rst)
      seen_high = 1'b1;
    else if (seen_high && rst_low < 0)
      rst_low = cyc - s0;
  end

  task automatic setup(input int tgt, input bit z);
    pos = 0;
    target = tgt;
    zero_mode = z;
    nslips = 0;
    last_bs = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s0 = cyc + 1;
    seen_high = 1'b0;
    rst_low = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (aligned || fail) begin
        ok = 1'b1;
        lat = cyc - s0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({serdes_rst, serdes_ce, bitslip, busy, aligned, fail, slip_cnt}
        !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL reset_vals got=%b want=100000000",
               {serdes_rst, serdes_ce, bitslip, busy, aligned, fail, slip_cnt});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({serdes_rst, serdes_ce, busy, aligned, fail} !== 5'b10000) begin
      failures++;
      $display("FAIL idle_vals got=%b want=10000",
               {serdes_rst, serdes_ce, busy, aligned, fail});
    end
  endtask

  task automatic test_aligned();
    exp_t e;
    int   lat;
    bit   ok;
    setup(0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 0, 0, 41});
    pulse_start();
    checks++;
    if (busy !== 1'b0 || serdes_rst !== 1'b1) begin
      failures++;
      $display("FAIL start_edge busy=%b rst=%b want 0 1", busy, serdes_rst);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || serdes_rst !== 1'b1 || serdes_ce !== 1'b0) begin
      failures++;
      $display("FAIL srst_outs busy=%b rst=%b ce=%b want 1 1 0",
               busy, serdes_rst, serdes_ce);
    end
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL aligned_timeout got none want done");
    end
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL aligned_lat got=%0d want=%0d", lat, e.lat);
    end
    checks++;
    if ({aligned, fail, busy, serdes_ce} !== {e.al, e.fl, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL aligned_flags got=%b want=%b",
               {aligned, fail, busy, serdes_ce}, {e.al, e.fl, 2'b01});
    end
    checks++;
    if (slip_cnt !== 3'(e.sc) || nslips !== e.ns) begin
      failures++;
      $display("FAIL aligned_slips got=%0d/%0d want=%0d/%0d",
               slip_cnt, nslips, e.sc, e.ns);
    end
    checks++;
    if (rst_low !== 9) begin
      failures++;
      $display("FAIL aligned_rst_rel got=%0d want=9", rst_low);
    end
  endtask

  task automatic test_offset3();
    exp_t e;
    int   lat;
    bit   ok;
    setup(3, 1'b0);
    sb.push_back('{1'b1, 1'b0, 3, 3, 59});
    pulse_start();
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat) begin
      failures++;
      $display("FAIL off3_lat got=%0d want=%0d", lat, e.lat);
    end
    checks++;
    if ({aligned, fail, busy} !== {e.al, e.fl, 1'b0}) begin
      failures++;
      $display("FAIL off3_flags got=%b want=%b",
               {aligned, fail, busy}, {e.al, e.fl, 1'b0});
    end
    checks++;
    if (slip_cnt !== 3'(e.sc) || nslips !== e.ns) begin
      failures++;
      $display("FAIL off3_slips got=%0d/%0d want=%0d/%0d",
               slip_cnt, nslips, e.sc, e.ns);
    end
  endtask

  task automatic test_never();
    exp_t e;
    int   lat;
    bit   ok;
    setup(0, 1'b1);
    sb.push_back('{1'b0, 1'b1, 7, 7, 68});
    pulse_start();
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat) begin
      failures++;
      $display("FAIL never_lat got=%0d want=%0d", lat, e.lat);
    end
    checks++;
    if ({aligned, fail, busy, serdes_rst} !== {e.al, e.fl, 2'b00}) begin
      failures++;
      $display("FAIL never_flags got=%b want=%b",
               {aligned, fail, busy, serdes_rst}, {e.al, e.fl, 2'b00});
    end
    checks++;
    if (slip_cnt !== 3'(e.sc) || nslips !== e.ns) begin
      failures++;
      $display("FAIL never_slips got=%0d/%0d want=%0d/%0d",
               slip_cnt, nslips, e.sc, e.ns);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   lat;
    bit   ok;
    setup(0, 1'b0);
    // 10th compare sample mismatches; the slip then lands on position 1
    sb.push_back('{1'b1, 1'b0, 1, 1, 56});
    pulse_start();
    while (cyc < s0 + 33) @(negedge clk);
    target = 1;
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat) begin
      failures++;
      $display("FAIL glitch_lat got=%0d want=%0d", lat, e.lat);
    end
    checks++;
    if ({aligned, fail} !== {e.al, e.fl}) begin
      failures++;
      $display("FAIL glitch_flags got=%b want=%b",
               {aligned, fail}, {e.al, e.fl});
    end
    checks++;
    if (slip_cnt !== 3'(e.sc) || nslips !== e.ns) begin
      failures++;
      $display("FAIL glitch_slips got=%0d/%0d want=%0d/%0d",
               slip_cnt, nslips, e.sc, e.ns);
    end
  endtask

  task automatic test_start_busy();
    exp_t e;
    int   lat;
    bit   ok;
    setup(0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 0, 0, 41});
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat || aligned !== e.al) begin
      failures++;
      $display("FAIL busy_start got lat=%0d al=%b want lat=%0d al=%b",
               lat, aligned, e.lat, e.al);
    end
    sb.push_back('{1'b1, 1'b0, 0, 0, 41});
    pulse_start();
    @(negedge clk);
    checks++;
    if ({aligned, serdes_rst, busy} !== 3'b011) begin
      failures++;
      $display("FAIL relock_entry got=%b want=011",
               {aligned, serdes_rst, busy});
    end
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat || aligned !== e.al) begin
      failures++;
      $display("FAIL relock got lat=%0d al=%b want lat=%0d al=%b",
               lat, aligned, e.lat, e.al);
    end
    checks++;
    if (rst_low !== 9) begin
      failures++;
      $display("FAIL relock_rst_rel got=%0d want=9", rst_low);
    end
  endtask

  task automatic test_reset_swait();
    setup(3, 1'b0);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nslips >= 1) break;
    end
    checks++;
    if (nslips !== 1 || busy !== 1'b1 || slip_cnt !== 3'd1) begin
      failures++;
      $display("FAIL swait_reach got slips=%0d busy=%b cnt=%0d want 1 1 1",
               nslips, busy, slip_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({serdes_rst, serdes_ce, bitslip, busy, aligned, fail, slip_cnt}
        !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL swait_rst got=%b want=100000000",
               {serdes_rst, serdes_ce, bitslip, busy, aligned, fail, slip_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if ({serdes_rst, busy, aligned, fail, slip_cnt} !== 7'b100_0000 ||
        nslips !== 1) begin
      failures++;
      $display("FAIL post_rst_idle got=%b slips=%0d want=1000000 slips=1",
               {serdes_rst, busy, aligned, fail, slip_cnt}, nslips);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset3();
    test_never();
    test_glitch();
    test_start_busy();
    test_reset_swait();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
